fp_mult_driver: RTL and testbench

- Upstream sequencer for the serial-bus floating-point multiplier.
- Accepts one operand pair at a time on a valid/ready interface.
- Runs the multiplier's start / operand-A / operand-B bus protocol, tracks the multiplier's done signalling to find result completion, and captures the product into an output register with valid/ready handshake.
- Sits between the operand source (register file or command decoder) and the multiplier.

---
 rtl/fp_mult_driver.sv | 158 +++++++++++++++
 tb/tb_fp_mult_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_driver.sv
// Sequencer for the serial-bus FP multiplier: accepts an operand pair, runs the
// start/A/B bus protocol, counts doneFP rising edges and captures the product.
module fp_mult_driver #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TW      = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic        out_special,
   output logic        timeout_err,
   output logic [31:0] inBus,
   output logic        startFP,
   input  logic [31:0] resBus,
   input  logic        doneFP
);

   typedef enum logic [2:0] {
      IDLE, START, INIT, SEND_A, SEND_B, WAIT, CAPTURE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        special_q, special_d;
   logic [1:0]  edge_cnt_q, edge_cnt_d;
   logic [TW-1:0] wait_cnt_q, wait_cnt_d;
   logic        prev_done_q, prev_done_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_res_q, out_res_d;
   logic        out_special_q, out_special_d;
   logic        timeout_err_q, timeout_err_d;
   logic        in_ready_q, in_ready_d;
   logic [31:0] inBus_q, inBus_d;
   logic        startFP_q, startFP_d;

   logic       rise;
   logic [1:0] edges_needed;

   assign rise         = doneFP & ~prev_done_q;
   assign edges_needed = special_q ? 2'd1 : 2'd2;

   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      special_d     = special_q;
      edge_cnt_d    = edge_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      prev_done_d   = prev_done_q;
      out_valid_d   = out_valid_q;
      out_res_d     = out_res_q;
      out_special_d = out_special_q;
      timeout_err_d = timeout_err_q;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d       = in_a;
               b_d       = in_b;
               special_d = (in_a[30:23] == 8'hFF) | (in_b[30:23] == 8'hFF) |
                           (in_a[30:0] == 31'd0)  | (in_b[30:0] == 31'd0);
               state_d   = START;
            end
         end
         START:  state_d = INIT;
         INIT:   state_d = SEND_A;
         SEND_A: state_d = SEND_B;
         SEND_B: begin
            edge_cnt_d  = '0;
            wait_cnt_d  = '0;
            prev_done_d = 1'b0;
            state_d     = WAIT;
         end
         WAIT: begin
            prev_done_d = doneFP;
            // A completing edge wins over a timeout landing on the same cycle.
            if (rise && (edge_cnt_q + 2'd1) == edges_needed) begin
               state_d = CAPTURE;
            end else begin
               if (rise) edge_cnt_d = edge_cnt_q + 2'd1;
               if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                  timeout_err_d = 1'b1;
                  state_d       = IDLE;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
         end
         CAPTURE: begin
            out_res_d     = resBus;
            out_special_d = special_q;
            out_valid_d   = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      startFP_d  = (state_d == START);
      in_ready_d = (state_d == IDLE) & ~out_valid_d & doneFP;
      case (state_d)
         START, INIT, SEND_A: inBus_d = a_d;
         SEND_B:              inBus_d = b_d;
         default:             inBus_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         special_q     <= 1'b0;
         edge_cnt_q    <= '0;
         wait_cnt_q    <= '0;
         prev_done_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         out_res_q     <= '0;
         out_special_q <= 1'b0;
         timeout_err_q <= 1'b0;
         in_ready_q    <= 1'b0;
         inBus_q       <= '0;
         startFP_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         special_q     <= special_d;
         edge_cnt_q    <= edge_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         prev_done_q   <= prev_done_d;
         out_valid_q   <= out_valid_d;
         out_res_q     <= out_res_d;
         out_special_q <= out_special_d;
         timeout_err_q <= timeout_err_d;
         in_ready_q    <= in_ready_d;
         inBus_q       <= inBus_d;
         startFP_q     <= startFP_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_res     = out_res_q;
   assign out_special = out_special_q;
   assign timeout_err = timeout_err_q;
   assign inBus       = inBus_q;
   assign startFP     = startFP_q;

endmodule

// File: tb/tb_fp_mult_driver.sv
// Bench for fp_mult_driver with a cycle-level model of the serial multiplier.
module tb_fp_mult_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_res;
   logic        out_special;
   logic        timeout_err;
   logic [31:0] inBus;
   logic        startFP;
   logic [31:0] resBus;
   logic        doneFP;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp_mult_driver #(.TIMEOUT(64), .TW(7)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .out_special(out_special), .timeout_err(timeout_err),
      .inBus(inBus), .startFP(startFP), .resBus(resBus), .doneFP(doneFP)
   );

   // Multiplier model: done drops after start, A/B taken off the bus, then one
   // done edge (special) or a normalise pulse plus a final edge (normal).
   logic        m_busy, m_hang, m_release, m_special;
   logic [31:0] m_prod, m_acap, m_bcap;
   int          m_cyc;

   initial begin
      m_hang = 1'b0; m_release = 1'b0; m_special = 1'b0; m_prod = '0;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         doneFP <= 1'b1; resBus <= '0; m_busy <= 1'b0; m_cyc <= 0;
      end else if (m_busy && m_release) begin
         m_busy <= 1'b0; doneFP <= 1'b1;
      end else if (!m_busy) begin
         if (startFP) begin
            m_busy <= 1'b1; m_cyc <= 0; doneFP <= 1'b0; resBus <= 32'hDEADBEEF;
         end
      end else begin
         m_cyc <= m_cyc + 1;
         if (m_cyc == 1) m_acap <= inBus;
         if (m_cyc == 2) m_bcap <= inBus;
         if (!m_hang) begin
            if (m_special) begin
               if (m_cyc == 4) begin doneFP <= 1'b1; resBus <= m_prod; m_busy <= 1'b0; end
            end else begin
               if (m_cyc == 5) doneFP <= 1'b1;
               if (m_cyc == 6) doneFP <= 1'b0;
               if (m_cyc == 12) begin doneFP <= 1'b1; resBus <= m_prod; m_busy <= 1'b0; end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Waits (bounded) for in_ready, presents the pair for one accept edge and
   // returns at the negedge of cycle 1.
   task automatic accept(input string name, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      in_a = a; in_b = b; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prod, input logic sp, input int lat,
                         input bit do_release);
      int k;
      int starts;
      m_prod = prod; m_special = sp;
      accept(name, a, b);
      k = 1;
      starts = startFP ? 1 : 0;
      while (!out_valid && k < 200) begin
         @(negedge clk); k++;
         if (startFP) starts++;
      end
      chk({name, "_latency"}, 32'(k), 32'(lat));
      chk({name, "_res"}, out_res, prod);
      chk({name, "_special"}, {31'd0, out_special}, {31'd0, sp});
      chk({name, "_start_pulses"}, 32'(starts), 32'd1);
      chk({name, "_busA"}, m_acap, a);
      chk({name, "_busB"}, m_bcap, b);
      if (do_release) begin
         out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready = 1'b0;
         chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
         chk({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] prod;
      logic        sp;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int k;
      bit ov_seen;
      logic [31:0] held;

      vecs[0] = '{"two_x_three",  32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 17};
      vecs[1] = '{"zero_x_five",  32'h00000000, 32'h40A00000, 32'h00000000, 1'b1, 9};
      vecs[2] = '{"inf_x_zero",   32'h7F800000, 32'h00000000, 32'hFFC00000, 1'b1, 9};
      vecs[3] = '{"inf_x_one",    32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 9};
      vecs[4] = '{"one_x_one",    32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 17};
      vecs[5] = '{"neg2_x_three", 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 17};
      vecs[6] = '{"negzero_x_1",  32'h80000000, 32'h3F800000, 32'h80000000, 1'b1, 9};
      vecs[7] = '{"nan_x_two",    32'h7FC00000, 32'h40000000, 32'h7FC00000, 1'b1, 9};

      repeat (3) @(negedge clk);
      chk("rst_in_ready",  {31'd0, in_ready},    32'd0);
      chk("rst_out_valid", {31'd0, out_valid},   32'd0);
      chk("rst_out_res",   out_res,              32'd0);
      chk("rst_special",   {31'd0, out_special}, 32'd0);
      chk("rst_timeout",   {31'd0, timeout_err}, 32'd0);
      chk("rst_inBus",     inBus,                32'd0);
      chk("rst_startFP",   {31'd0, startFP},     32'd0);
      rst = 1'b0;

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].sp, vecs[i].lat, 1'b1);

      // Backpressure: result held for 20 cycles with out_ready low.
      run_op("bp", 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 17, 1'b0);
      held = out_res;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
         chk("bp_res_hold",   out_res, held);
         chk("bp_ready_low",  {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("bp_ready_back", {31'd0, in_ready},  32'd1);

      // Timeout: multiplier never signals completion.
      m_hang = 1'b1; m_special = 1'b0; m_prod = 32'h40C00000;
      accept("to", 32'h40000000, 32'h40400000);
      k = 1; ov_seen = 1'b0;
      while (!timeout_err && k < 200) begin
         @(negedge clk); k++;
         if (out_valid) ov_seen = 1'b1;
      end
      chk("to_latency",   32'(k), 32'd69);
      chk("to_no_valid",  {31'd0, ov_seen}, 32'd0);
      chk("to_ready_low", {31'd0, in_ready}, 32'd0);
      m_release = 1'b1;
      @(negedge clk);
      m_release = 1'b0; m_hang = 1'b0;
      run_op("after_to", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 17, 1'b1);
      chk("to_sticky", {31'd0, timeout_err}, 32'd1);

      // Reset during WAIT of 1.5 x 1.5.
      m_special = 1'b0; m_prod = 32'h40100000;
      accept("rstop", 32'h3FC00000, 32'h3FC00000);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_in_ready",  {31'd0, in_ready},    32'd0);
      chk("mid_out_valid", {31'd0, out_valid},   32'd0);
      chk("mid_out_res",   out_res,              32'd0);
      chk("mid_special",   {31'd0, out_special}, 32'd0);
      chk("mid_timeout",   {31'd0, timeout_err}, 32'd0);
      chk("mid_inBus",     inBus,                32'd0);
      chk("mid_startFP",   {31'd0, startFP},     32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_op("after_rst", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 17, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
